// File: rtl/ling_wide_add_seq_if.sv
// Beat stream into the wide-add sequencer and result stream out of it.
// master = operand source / result sink, slave = the sequencer.
interface ling_wide_add_seq_if #(
   parameter int IDXW = 8
);
   logic            in_valid;
   logic            in_ready;
   logic [63:0]     in_a;
   logic [63:0]     in_b;
   logic            in_first;
   logic            in_last;
   logic            in_cin;
   logic            in_sub;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     out_sum;
   logic [IDXW-1:0] out_idx;
   logic            out_last;
   logic            out_cout;
   logic            out_err;

   modport master (
      output in_valid, in_a, in_b, in_first, in_last, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_err
   );

   modport slave (
      input  in_valid, in_a, in_b, in_first, in_last, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_err
   );
endinterface

// File: rtl/ling_wide_add_seq.sv
// Wide-operand add/subtract sequencer around a single 64-bit Ling adder.
// Operands arrive LS word first; the adder carry is chained between beats
// and each word's result lands in a one-deep output register.

// Combinational 64-bit Ling adder. The pseudo-carry H(i+1) = g(i) | t(i-1)&H(i)
// is resolved with a Kogge-Stone prefix, and the real carry is t(i-1)&H(i).
module ling_64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);
   logic [63:0] g, p, t, tp, hv, c;
   logic [63:0] gg [0:6];
   logic [63:0] pp [0:6];

   assign g  = a & b;
   assign p  = a ^ b;
   assign t  = a | b;
   // Ling propagate for bit i is t(i-1); below bit 0 it is 1 so cin enters H directly.
   assign tp = {t[62:0], 1'b1};

   assign gg[0] = g;
   assign pp[0] = tp;

   for (genvar k = 0; k < 6; k++) begin : g_lvl
      localparam int D = 1 << k;
      for (genvar i = 0; i < 64; i++) begin : g_bit
         if (i >= D) begin : g_merge
            assign gg[k+1][i] = gg[k][i] | (pp[k][i] & gg[k][i-D]);
            assign pp[k+1][i] = pp[k][i] & pp[k][i-D];
         end else begin : g_pass
            assign gg[k+1][i] = gg[k][i];
            assign pp[k+1][i] = pp[k][i];
         end
      end
   end

   // hv[i] holds H(i+1), including the carry-in term.
   assign hv   = gg[6] | (pp[6] & {64{cin}});
   assign c    = {t[62:0] & hv[62:0], cin};
   assign sum  = p ^ c;
   assign cout = t[63] & hv[63];
endmodule

module ling_wide_add_seq #(
   parameter int WORDS = 4,
   parameter int IDXW  = 8
) (
   input  logic               clk,
   input  logic               rst,
   ling_wide_add_seq_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic            carry_q, carry_d;
   logic            mode_q, mode_d;
   logic            accept;
   logic            first_beat;
   logic            force_last;
   logic            last_d;
   logic            err_d;
   logic [IDXW-1:0] idx_d;
   logic            add_cin;
   logic [63:0]     add_b;
   logic [63:0]     add_sum;
   logic            add_cout;

   logic            out_valid_q;
   logic [63:0]     out_sum_q;
   logic [IDXW-1:0] out_idx_q;
   logic            out_last_q, out_cout_q, out_err_q;

   // Output slot is free when empty or draining this cycle; closed during reset.
   assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_err   = out_err_q;

   ling_64 u_add (
      .a    (bus.in_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Beat classification, operand conditioning and next state.
   always_comb begin
      state_d    = state_q;
      carry_d    = carry_q;
      mode_d     = mode_q;
      // A beat opens a packet when explicitly flagged or when nothing is open.
      first_beat = (state_q == IDLE) || bus.in_first;
      idx_d      = first_beat ? '0 : out_idx_q + IDXW'(1);
      add_cin    = first_beat ? (bus.in_sub | bus.in_cin) : carry_q;
      add_b      = (first_beat ? bus.in_sub : mode_q) ? ~bus.in_b : bus.in_b;
      force_last = (idx_d == IDXW'(WORDS - 1)) && !bus.in_last;
      last_d     = bus.in_last || force_last;
      // Missing first flag, restart mid-packet, or overrun all mark the result.
      err_d      = ((state_q == IDLE) && !bus.in_first) ||
                   ((state_q == BUSY) && bus.in_first) || force_last;
      if (accept) begin
         if (first_beat) mode_d = bus.in_sub;
         carry_d = last_d ? 1'b0 : add_cout;
         state_d = last_d ? IDLE : BUSY;
      end
   end

   // Control state: FSM, chained carry and packet mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         mode_q  <= mode_d;
      end
   end

   // One-deep result register; loads on accept, empties on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_sum_q   <= add_sum;
         out_idx_q   <= idx_d;
         out_last_q  <= last_d;
         out_cout_q  <= add_cout;
         out_err_q   <= err_d;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ling_wide_add_seq.sv
// Directed checks of the wide-add sequencer: chaining, subtract, stalls,
// protocol errors and mid-packet reset.
module tb_ling_wide_add_seq;
   localparam int WORDS = 4;
   localparam int IDXW  = 8;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ling_wide_add_seq_if #(.IDXW(IDXW)) bus ();

   ling_wide_add_seq #(.WORDS(WORDS), .IDXW(IDXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic first, input logic last, input logic cin, input logic sub);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_first = first;
      bus.in_last  = last;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
   endtask

   task automatic chk_out(input string tag, input logic [63:0] sum, input logic cout,
                          input int idx, input logic last, input logic err);
      chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " sum"},   bus.out_sum, sum);
      chk({tag, " cout"},  64'(bus.out_cout), 64'(cout));
      chk({tag, " idx"},   64'(bus.out_idx), 64'(idx));
      chk({tag, " last"},  64'(bus.out_last), 64'(last));
      chk({tag, " err"},   64'(bus.out_err), 64'(err));
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      bus.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst out_sum", bus.out_sum, 64'd0);
      chk("rst out_idx", 64'(bus.out_idx), 64'd0);
      chk("rst flags", {61'd0, bus.out_last, bus.out_cout, bus.out_err}, 64'd0);
      rst = 1'b0;
      #1;
      chk("idle in_ready", 64'(bus.in_ready), 64'd1);

      // Single-word add with wrap
      drive(1, ONES, 64'd1, 1, 1, 0, 0);
      tick();
      chk_out("t1", 64'd0, 1, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("t1 drained", 64'(bus.out_valid), 64'd0);

      // Two-word carry chain
      drive(1, ONES, 64'd1, 1, 0, 0, 0);
      tick();
      chk_out("t2 w0", 64'd0, 1, 0, 0, 0);
      drive(1, 64'd0, 64'd0, 0, 1, 0, 0);
      tick();
      chk_out("t2 w1", 64'd1, 0, 1, 1, 0);

      // 128-bit subtract: 2^64 - 1
      drive(1, 64'd0, 64'd1, 1, 0, 0, 1);
      tick();
      chk_out("t3 w0", ONES, 0, 0, 0, 0);
      drive(1, 64'd1, 64'd0, 0, 1, 0, 0);
      tick();
      chk_out("t3 w1", 64'd0, 1, 1, 1, 0);

      // Backpressure during a 4-beat add
      drive(1, ONES, 64'd1, 1, 0, 0, 0);
      tick();
      chk_out("t4 w0", 64'd0, 1, 0, 0, 0);
      bus.out_ready = 1'b0;
      drive(1, 64'd5, 64'd7, 0, 0, 0, 0);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t4 stall in_ready", 64'(bus.in_ready), 64'd0);
         tick();
         chk_out("t4 stall", 64'd0, 1, 0, 0, 0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("t4 resume in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk_out("t4 w1", 64'hD, 0, 1, 0, 0);
      drive(1, ONES, 64'd1, 0, 0, 0, 0);
      tick();
      chk_out("t4 w2", 64'd0, 1, 2, 0, 0);
      drive(1, 64'h10, 64'h20, 0, 1, 0, 0);
      tick();
      chk_out("t4 w3", 64'h31, 0, 3, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("t4 no dup", 64'(bus.out_valid), 64'd0);

      // Restart mid-packet
      drive(1, 64'd1, 64'd2, 1, 0, 0, 0);
      tick();
      chk_out("t5 w0", 64'd3, 0, 0, 0, 0);
      drive(1, 64'd3, 64'd4, 1, 0, 0, 0);
      tick();
      chk_out("t5 restart", 64'd7, 0, 0, 0, 1);
      drive(1, 64'd0, 64'd0, 0, 1, 0, 0);
      tick();
      chk_out("t5 close", 64'd0, 0, 1, 1, 0);

      // Overrun: no in_last within WORDS beats
      for (int i = 0; i < WORDS; i++) begin
         drive(1, 64'(i), 64'd0, (i == 0), 0, 0, 0);
         tick();
         chk_out("t6 beat", 64'(i), 0, i, (i == WORDS - 1), (i == WORDS - 1));
      end
      // Next beat lacks in_first: treated as first, uses in_cin, flagged
      drive(1, 64'd9, 64'd1, 0, 1, 1, 0);
      tick();
      chk_out("t6 orphan", 64'hB, 0, 0, 1, 1);

      // Reset mid-packet discards carry
      drive(1, ONES, 64'd1, 1, 0, 0, 0);
      tick();
      drive(1, 64'd0, 64'd0, 0, 0, 0, 0);
      tick();
      chk_out("t7 w1", 64'd1, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      chk("t7 rst valid", 64'(bus.out_valid), 64'd0);
      rst = 1'b0;
      drive(1, 64'd5, 64'd6, 1, 1, 0, 0);
      tick();
      chk_out("t7 fresh", 64'hB, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
